// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM encoding and event record for ps2_key_ctrl.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_SETTLE,
        ST_DECODE
    } state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    function automatic logic is_mod(input logic [7:0] c);
        return (c == SC_LSHIFT) || (c == SC_RSHIFT) ||
               (c == SC_CTRL)   || (c == SC_ALT);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Key-event valid/ready channel from ps2_key_ctrl to its consumer.
interface ps2_key_ctrl_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_brk;
    logic       evt_ext;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_brk,
        output evt_ext,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_brk,
        input  evt_ext,
        output evt_ready
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO; head word is forced to zero while empty.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 byte sequencer: prefix assembly, modifier/caps tracking, event FIFO.
// Build macro TYPEMATIC_FILTER_EN drops auto-repeat makes of the held key.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           kb_ready,
    input  logic [7:0]     kb_data,
    input  logic           kb_overflow,
    output logic           nextdata_n,
    ps2_key_ctrl_if.master evt,
    output logic           shift,
    output logic           ctrl,
    output logic           alt,
    output logic           caps,
    output logic           ovf_seen,
    input  logic           ovf_clr
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    state_e     state_q, state_d;
    logic [7:0] byte_q;
    logic       byte_load;
    logic [2:0] skip_q, skip_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       push, done, drop;
    logic       fifo_full, fifo_empty;
    evt_t       push_evt, head;
    logic       lsh_q, rsh_q, lctl_q, rctl_q, lalt_q, ralt_q;
    logic       caps_q, caps_held_q, ovf_q;

    always_comb begin
        state_d   = state_q;
        byte_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (kb_ready && !fifo_full) begin
                    byte_load = 1'b1;
                    state_d   = ST_POP;
                end
            end
            ST_POP:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        skip_d   = skip_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        push     = 1'b0;
        done     = 1'b0;
        push_evt = '0;
        if (state_q == ST_DECODE) begin
            priority case (1'b1)
                (skip_q != 3'd0): skip_d = skip_q - 3'd1;
                (byte_q == SC_E1): begin
                    skip_d        = 3'd7;
                    push          = 1'b1;
                    push_evt.code = SC_E1;
                end
                (byte_q == SC_E0): ext_d = 1'b1;
                (byte_q == SC_F0): brk_d = 1'b1;
                default: begin
                    done     = 1'b1;
                    push     = !drop;
                    push_evt = '{ext: ext_q, brk: brk_q, code: byte_q};
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            endcase
        end
    end

    // nextdata_n comes straight from a flop, so it can only be low in POP.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            byte_q     <= '0;
            nextdata_n <= 1'b1;
            skip_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nextdata_n <= (state_d != ST_POP);
            skip_q     <= skip_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            if (byte_load) byte_q <= kb_data;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] held_code_q;
    logic       held_ext_q;
    logic       match;

    assign match = (byte_q == held_code_q) && (ext_q == held_ext_q);
    assign drop  = !brk_q && match;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_code_q <= '0;
            held_ext_q  <= 1'b0;
        end else if (done) begin
            if (brk_q && match) begin
                held_code_q <= '0;
                held_ext_q  <= 1'b0;
            end else if (!brk_q && !is_mod(byte_q)) begin
                held_code_q <= byte_q;
                held_ext_q  <= ext_q;
            end
        end
    end
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lsh_q       <= 1'b0;
            rsh_q       <= 1'b0;
            lctl_q      <= 1'b0;
            rctl_q      <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else if (done) begin
            if (byte_q == SC_LSHIFT) lsh_q <= !brk_q;
            if (byte_q == SC_RSHIFT) rsh_q <= !brk_q;
            if (byte_q == SC_CTRL) begin
                if (ext_q) rctl_q <= !brk_q;
                else       lctl_q <= !brk_q;
            end
            if (byte_q == SC_ALT) begin
                if (ext_q) ralt_q <= !brk_q;
                else       lalt_q <= !brk_q;
            end
            // Held CapsLock repeats must not toggle again.
            if (byte_q == SC_CAPS && !ext_q) begin
                if (!brk_q && !caps_held_q) caps_q <= !caps_q;
                caps_held_q <= !brk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ovf_q <= 1'b0;
        end else if (kb_overflow) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign shift    = lsh_q | rsh_q;
    assign ctrl     = lctl_q | rctl_q;
    assign alt      = lalt_q | ralt_q;
    assign caps     = caps_q;
    assign ovf_seen = ovf_q;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .W     (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .din   (push_evt),
        .pop   (!fifo_empty && evt.evt_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_code  = head.code;
    assign evt.evt_brk   = head.brk;
    assign evt.evt_ext   = head.ext;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: receiver model, random consumer, key model.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_overflow = 1'b0;
    logic       nextdata_n;
    logic       shift, ctrl, alt, caps, ovf_seen;
    logic       ovf_clr = 1'b0;

    ps2_key_ctrl_if evt_if ();

    ps2_key_ctrl #(.FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .kb_ready    (kb_ready),
        .kb_data     (kb_data),
        .kb_overflow (kb_overflow),
        .nextdata_n  (nextdata_n),
        .evt         (evt_if),
        .shift       (shift),
        .ctrl        (ctrl),
        .alt         (alt),
        .caps        (caps),
        .ovf_seen    (ovf_seen),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int pop_cnt = 0;
    int since = 100;
    int rdy_mode = 1;

    logic [7:0] rx_q[$];
    logic [9:0] exp_q[$];

    // Reference key model: prefixes, pressed-key set, caps, held key.
    int         m_skip = 0;
    bit         m_ext = 0;
    bit         m_brk = 0;
    bit         m_caps = 0;
    bit         down[int];
    logic [7:0] m_hcode = 8'h00;
    bit         m_hext = 0;

    task automatic chk(input string name, input int got, input int req);
        n_chk++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    function automatic int key_of(input bit e, input logic [7:0] c);
        if (c == 8'h12 || c == 8'h59) return int'(c);
        return (e ? 256 : 0) + int'(c);
    endfunction

    function automatic void model(input logic [7:0] b);
        bit make;
        bit keep;
        int k;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
            exp_q.push_back({2'b00, 8'hE1});
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            make = !m_brk;
            keep = 1;
            k = key_of(m_ext, b);
`ifdef TYPEMATIC_FILTER_EN
            if (b == m_hcode && m_ext == m_hext) begin
                if (make) keep = 0;
                else begin m_hcode = 8'h00; m_hext = 0; end
            end else if (make && !(b inside {8'h12, 8'h59, 8'h14, 8'h11})) begin
                m_hcode = b;
                m_hext = m_ext;
            end
`endif
            if (b == 8'h58 && !m_ext && make && !down.exists(k)) m_caps = !m_caps;
            if (make) down[k] = 1;
            else if (down.exists(k)) down.delete(k);
            if (keep) exp_q.push_back({m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic void model_reset();
        m_skip = 0; m_ext = 0; m_brk = 0; m_caps = 0;
        m_hcode = 8'h00; m_hext = 0;
        down.delete();
    endfunction

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
        model(b);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((rx_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        chk({"drain_", tag}, (rx_q.size() + exp_q.size()), 0);
    endtask

    task automatic check_mods(input string tag);
        chk({"shift_", tag}, shift, int'(down.exists(8'h12) || down.exists(8'h59)));
        chk({"ctrl_", tag}, ctrl, int'(down.exists(8'h14) || down.exists(256 + 8'h14)));
        chk({"alt_", tag}, alt, int'(down.exists(8'h11) || down.exists(256 + 8'h11)));
        chk({"caps_", tag}, caps, int'(m_caps));
    endtask

    task automatic check_reset(input string tag);
        chk({"rst_ndn_", tag}, nextdata_n, 1);
        chk({"rst_valid_", tag}, evt_if.evt_valid, 0);
        chk({"rst_head_", tag}, {evt_if.evt_ext, evt_if.evt_brk, evt_if.evt_code}, 0);
        chk({"rst_mods_", tag}, {shift, ctrl, alt, caps, ovf_seen}, 0);
    endtask

    // Receiver model: head byte shown on kb_data, popped by nextdata_n.
    always @(negedge clk) begin
        if (!clrn) begin
            since = 100;
        end else if (nextdata_n == 1'b0) begin
            chk("pop_gap_ge4", int'(since >= 4), 1);
            chk("pop_nonempty", int'(rx_q.size() != 0), 1);
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            pop_cnt++;
            since = 1;
        end else begin
            since++;
        end
        kb_ready = (rx_q.size() != 0);
        kb_data  = kb_ready ? rx_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       evt_if.evt_ready = 1'b0;
            2:       evt_if.evt_ready = 1'b1;
            default: evt_if.evt_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: every accepted head event is checked against the scoreboard.
    always @(negedge clk) begin
        if (clrn && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL evt_unexpected: got %h required none",
                         {evt_if.evt_ext, evt_if.evt_brk, evt_if.evt_code});
            end else begin
                chk("evt", {evt_if.evt_ext, evt_if.evt_brk, evt_if.evt_code},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [8:0] keys [12];
    logic [8:0] k;
    bit         rb;
    int         p0;
    int         hi;

    task automatic send_pause();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    endtask

    initial begin
        keys = '{9'h01C, 9'h012, 9'h059, 9'h014, 9'h114, 9'h011,
                 9'h111, 9'h058, 9'h175, 9'h023, 9'h16B, 9'h029};
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("break");
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain("ext");
        send(8'h12); send(8'h1C);
        drain("shift_on");
        check_mods("shift_on");
        send(8'hF0); send(8'h12);
        drain("shift_off");
        check_mods("shift_off");
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        drain("caps1");
        check_mods("caps1");
        send(8'h58);
        drain("caps0");
        check_mods("caps0");
        p0 = pop_cnt;
        send_pause();
        drain("pause");
        chk("pause_pops", pop_cnt - p0, 8);
        check_mods("pause");

        // Backpressure: nine makes into an eight-deep FIFO.
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        p0 = pop_cnt;
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        send(8'h35); send(8'h3C); send(8'h43); send(8'h44);
        repeat (80) @(negedge clk);
        chk("full_pops", pop_cnt - p0, 8);
        chk("full_rx_left", rx_q.size(), 1);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += nextdata_n;
        end
        chk("full_ndn_high", hi, 10);
        rdy_mode = 2;
        @(negedge clk);
        rdy_mode = 0;
        repeat (20) @(negedge clk);
        chk("full_admit", pop_cnt - p0, 9);
        rdy_mode = 1;
        drain("full");

        // Overflow flag: set, set-beats-clear, clear.
        kb_overflow = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_set", ovf_seen, 1);
        kb_overflow = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        chk("ovf_set_wins", ovf_seen, 1);
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", ovf_seen, 0);

        // Reset between E0 and its code discards the prefix.
        send(8'h12);
        send(8'hE0);
        drain("pre_rst");
        clrn = 1'b0;
        model_reset();
        #1;
        check_reset("mid");
        @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h1C);
        drain("post_rst");

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                send_pause();
            end else begin
                k  = keys[$urandom_range(0, 11)];
                rb = ($urandom_range(0, 2) == 0);
                if (k[8]) send(8'hE0);
                if (rb) send(8'hF0);
                send(k[7:0]);
            end
            if (i % 20 == 19) begin
                drain("rand");
                check_mods("rand");
            end
        end

`ifdef TYPEMATIC_FILTER_EN
        send(8'h1D); send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C);
        drain("typematic");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencer that sits between the ps2_keyboard receiver and the ASCII/display consumers.
- Drives the receiver's nextdata_n pop handshake.
- Assembles scan-code prefixes (E0 extended, F0 break, E1 pause) into single key events.
- Tracks modifier and CapsLock state.
- Buffers events in a small FIFO with a valid/ready interface for downstream logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
kb_ready  in  1  receiver ready (byte available)
kb_data  in  8  receiver head byte
kb_overflow  in  1  receiver overflow flag
nextdata_n  out  1  pop strobe to receiver, active low, one clk wide
evt_valid  out  1  event FIFO non-empty
evt_ready  in  1  consumer accepts head event
evt_code  out  8  head event scan code
evt_brk  out  1  head event is release
evt_ext  out  1  head event was E0-prefixed
shift  out  1  either Shift held
ctrl  out  1  either Ctrl held
alt  out  1  either Alt held
caps  out  1  CapsLock toggle state
ovf_seen  out  1  sticky: kb_overflow observed
ovf_clr  in  1  clears ovf_seen

Behaviour:
- Reset values: clk and clrn as named; reset is asynchronous, active-low. On reset: nextdata_n=1, evt_valid=0, evt_code/brk/ext=0, shift/ctrl/alt/caps=0, ovf_seen=0, FIFO empty, state IDLE. All prefix flags and the skip counter are cleared. Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, POP, SETTLE, DECODE.
  - IDLE: if kb_ready=1 and FIFO not full, latch kb_data into byte_q and go to POP. Otherwise stay.
  - POP: nextdata_n=0 for exactly this one cycle; go to SETTLE.
  - SETTLE: nextdata_n=1; one idle cycle so the receiver's read pointer and ready settle; go to DECODE.
  - DECODE: classify byte_q (below); go to IDLE. Minimum 4 clk per byte.
- nextdata_n is registered and glitch-free. It is never low for 2 consecutive cycles.
- Classification in DECODE, in priority order:
  1. skip_cnt≠0: decrement, drop the byte.
  2. E1: skip_cnt=7, then push one event {code=E1, brk=0, ext=0}.
  3. E0: ext_pend=1.
  4. F0: brk_pend=1.
  5. Otherwise: push event {code=byte_q, brk=brk_pend, ext=ext_pend}, then clear both pends.
- Modifier update on a completed event (non-E1):
  - 12/59 → shift bits.
  - 14 → ctrl (ext selects right side).
  - 11 → alt (ext selects right side).
  - Make sets the bit, break clears it.
  - shift/ctrl/alt are the OR of left and right.
- CapsLock, code 58 non-ext: caps toggles on make only when caps_held=0. Make sets caps_held; break clears it. Typematic repeats therefore do not re-toggle.
- Event FIFO: show-ahead. evt_* reflect the head entry whenever evt_valid=1. A pop happens when evt_valid & evt_ready.
  - The not-full check in IDLE guarantees a push never hits a full FIFO.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - evt_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- When the FIFO is full, bytes are left in the receiver (backpressure). A receiver overflow that results is reported via ovf_seen.
- ovf_seen: set on any cycle with kb_overflow=1. Cleared by ovf_clr=1. If set and clear occur together, set wins.

Optional Feature:
TYPEMATIC_FILTER_EN
- Defined: a held_code/held_ext register records the last non-modifier make event. A make event equal to held is not pushed; modifier and caps tracking still run. A break equal to held clears held and is pushed. Reset clears held to 0.
- Undefined: every make is pushed, including auto-repeats.

Decomposition:
Shared package ps2_pkg:
- Scan-code constants: SC_E0=E0, SC_E1=E1, SC_F0=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_ALT=11, SC_CAPS=58.
- FSM state encoding.
- Event record layout {ext, brk, code[7:0]}, 10 bits.

Sub-module ps2_evt_fifo: parameterised synchronous FIFO with show-ahead output, full/empty flags, and the same clk/clrn.

Test Plan:
- Bytes 1C, F0, 1C → events {1C,brk0,ext0} then {1C,brk1,ext0}. Each pop is exactly one nextdata_n low cycle, ≥4 clk apart.
- E0 75, E0 F0 75 → {75,0,1}, {75,1,1}. Bytes 12, 1C → shift=1 at the 1C event; F0 12 → shift=0.
- 58, 58, 58, F0 58 → caps toggles once (caps=1). A further 58 → caps=0.
- E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,0}. Eight pops; ctrl stays 0.
- evt_ready=0 with 9 make bytes, FIFO_DEPTH=8 → 8 events queued, 9th byte not popped (nextdata_n stays 1). A single pop then admits it.
- Assert clrn low between E0 and its code → all outputs at reset values. Next byte 1C → {1C,0,0}.
- (With TYPEMATIC_FILTER_EN) 1C, 1C, 1C, F0 1C → only {1C,0,0} and {1C,1,0} are pushed.
